// File: rtl/alarm_ringer.sv
`timescale 1ns/1ps
// alarm_ringer: fires on the rising edge of time==alarm equality, rings a gated
// tone until stop, snooze or timeout, and re-rings after a snooze period.
module alarm_ringer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TONE_DIV   = 25_000,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [3:0] state_mode,
  input  logic       alarm_en,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_minute,
  input  logic [7:0] alarm_second,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing
);

  localparam int unsigned PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned SNZ_SEC = SNOOZE_MIN * 60;
  localparam int unsigned RING_W  = $clog2(RING_SEC) + 1;
  localparam int unsigned SNZ_W   = $clog2(SNZ_SEC) + 1;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(CLK_HZ / 2);
  localparam logic [TONE_W-1:0] TONE_MAX  = TONE_W'(TONE_DIV - 1);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNZ_SEC);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  state_t              r_state, w_next;
  logic                r_stop_buf0, r_stop_buf1, r_snz_buf0, r_snz_buf1;
  logic                r_match_d, r_armed;
  logic [PRE_W-1:0]    r_pre;
  logic [TONE_W-1:0]   r_tone_cnt;
  logic                r_tone, r_buzzer;
  logic [RING_W-1:0]   r_ring_cnt;
  logic [SNZ_W-1:0]    r_snz_cnt;

  logic w_stop_press, w_snz_press, w_match, w_trigger, w_sec_tick, w_entry;
  logic w_ring_load, w_ring_dec, w_snz_load, w_snz_dec;

  assign w_stop_press = ~r_stop_buf0 & r_stop_buf1;
  assign w_snz_press  = ~r_snz_buf0 & r_snz_buf1;
  assign w_match      = (cur_hour == alarm_hour) && (cur_minute == alarm_minute) &&
                        (cur_second == alarm_second);
  // r_armed blocks a fire on an equality already present when reset releases:
  // the compare must be seen false at least once before an edge counts.
  assign w_trigger    = w_match & ~r_match_d & r_armed & alarm_en & (state_mode != 4'd3);
  assign w_sec_tick   = (r_pre == PRE_MAX);
  assign w_entry      = (w_next != r_state) && (w_next != S_IDLE);

  // Two-flop key synchronizers; idle (released) level is 1.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_stop_buf0 <= 1'b1;
      r_stop_buf1 <= 1'b1;
      r_snz_buf0  <= 1'b1;
      r_snz_buf1  <= 1'b1;
    end else begin
      r_stop_buf0 <= stop_key;
      r_stop_buf1 <= r_stop_buf0;
      r_snz_buf0  <= snooze_key;
      r_snz_buf1  <= r_snz_buf0;
    end
  end

  // Delayed match for edge detection, plus the post-reset arm flag.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_match_d <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_match_d <= w_match;
      r_armed   <= r_armed | ~w_match;
    end
  end

  // One-second prescaler, restarted on entry to RING or SNOOZE.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)          r_pre <= '0;
    else if (w_entry)    r_pre <= '0;
    else if (w_sec_tick) r_pre <= '0;
    else                 r_pre <= r_pre + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and counter-control decode, priorities as listed per state.
  always_comb begin
    w_next      = r_state;
    w_ring_load = 1'b0;
    w_ring_dec  = 1'b0;
    w_snz_load  = 1'b0;
    w_snz_dec   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_next      = S_RING;
          w_ring_load = 1'b1;
        end
      end
      S_RING: begin
        if (!alarm_en || w_stop_press) begin
          w_next = S_IDLE;
        end else if (w_snz_press) begin
          w_next     = S_SNOOZE;
          w_snz_load = 1'b1;
        end else if (w_sec_tick) begin
          if (r_ring_cnt == RING_W'(1)) w_next = S_IDLE;
          else                          w_ring_dec = 1'b1;
        end
      end
      S_SNOOZE: begin
        if (!alarm_en || w_stop_press) begin
          w_next = S_IDLE;
        end else if (w_sec_tick) begin
          if (r_snz_cnt == SNZ_W'(1)) begin
            w_next      = S_RING;
            w_ring_load = 1'b1;
          end else begin
            w_snz_dec = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Ring and snooze second counters.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
    end else begin
      if (w_ring_load)     r_ring_cnt <= RING_LOAD;
      else if (w_ring_dec) r_ring_cnt <= r_ring_cnt - RING_W'(1);
      if (w_snz_load)      r_snz_cnt  <= SNZ_LOAD;
      else if (w_snz_dec)  r_snz_cnt  <= r_snz_cnt - SNZ_W'(1);
    end
  end

  // Tone divider: runs only while ringing, otherwise parked at zero.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_state == S_RING) begin
      if (r_tone_cnt == TONE_MAX) begin
        r_tone_cnt <= '0;
        r_tone     <= ~r_tone;
      end else begin
        r_tone_cnt <= r_tone_cnt + 1'b1;
      end
    end else begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end
  end

  // Registered buzzer: tone gated by the first half of each second.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) r_buzzer <= 1'b0;
    else        r_buzzer <= (r_state == S_RING) & (r_pre < PRE_HALF) & r_tone;
  end

  assign buzzer   = r_buzzer;
  assign ringing  = (r_state == S_RING);
  assign snoozing = (r_state == S_SNOOZE);

endmodule

// File: tb/tb_alarm_ringer.sv
`timescale 1ns/1ps
// Bench for alarm_ringer: directed scenarios then random stimulus, every cycle
// checked against a cycle-count model of ring/snooze/tone behaviour.
module tb_alarm_ringer;

  localparam int CLK_HZ     = 10;
  localparam int TONE_DIV   = 2;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 1;
  localparam int RING_CYC   = RING_SEC * CLK_HZ;
  localparam int SNZ_CYC    = SNOOZE_MIN * 60 * CLK_HZ;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic [3:0] state_mode;
  logic       alarm_en;
  logic [7:0] cur_hour, cur_minute, cur_second;
  logic [7:0] alarm_hour, alarm_minute, alarm_second;
  logic       stop_key, snooze_key;
  logic       buzzer, ringing, snoozing;

  alarm_ringer #(
    .CLK_HZ(CLK_HZ), .TONE_DIV(TONE_DIV), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .state_mode(state_mode), .alarm_en(alarm_en),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_second(alarm_second),
    .stop_key(stop_key), .snooze_key(snooze_key),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing)
  );

  always #5 clk_50M = ~clk_50M;

  int total = 0;
  int bad   = 0;
  int cnt_ring = 0;
  int cnt_snz  = 0;

  // Model: 0 idle, 1 ring, 2 snooze; m_k = cycles spent in current state.
  int m_st, m_k;
  bit m_buz, m_prev;
  bit hs0, hs1, hz0, hz1;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_k = 0; m_buz = 0;
    m_prev = 1;  // nothing seen since reset: an equality already present is not an edge
    hs0 = 1; hs1 = 1; hz0 = 1; hz1 = 1;
  endtask

  task automatic model_edge();
    bit stop_p, snz_p, m, trig;
    stop_p = !hs0 && hs1;
    snz_p  = !hz0 && hz1;
    m = (cur_hour == alarm_hour) && (cur_minute == alarm_minute) && (cur_second == alarm_second);
    trig = m && !m_prev && alarm_en && (state_mode != 4'd3);
    m_buz = (m_st == 1) && ((m_k % CLK_HZ) < CLK_HZ / 2) && (((m_k / TONE_DIV) % 2) == 1);
    case (m_st)
      0: if (trig) begin m_st = 1; m_k = 0; end
      1: begin
        if (!alarm_en || stop_p)     m_st = 0;
        else if (snz_p)              begin m_st = 2; m_k = 0; end
        else if (m_k + 1 == RING_CYC) m_st = 0;
        else                         m_k++;
      end
      default: begin
        if (!alarm_en || stop_p)     m_st = 0;
        else if (m_k + 1 == SNZ_CYC) begin m_st = 1; m_k = 0; end
        else                         m_k++;
      end
    endcase
    hs1 = hs0; hs0 = stop_key;
    hz1 = hz0; hz0 = snooze_key;
    m_prev = m;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_50M); #1;
    check("ringing", ringing, m_st == 1);
    check("snoozing", snoozing, m_st == 2);
    check("buzzer", buzzer, m_buz);
    if (ringing === 1'b1)  cnt_ring++;
    if (snoozing === 1'b1) cnt_snz++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    cur_hour = h; cur_minute = mi; cur_second = s;
  endtask

  initial begin
    bit found;
    int r;
    rst_n = 1'b0; state_mode = 4'd0; alarm_en = 1'b1;
    alarm_hour = 8'd7; alarm_minute = 8'd30; alarm_second = 8'd0;
    set_cur(8'd7, 8'd29, 8'd59);
    stop_key = 1'b1; snooze_key = 1'b1;
    model_reset();

    // Reset state
    @(posedge clk_50M); @(posedge clk_50M); #1;
    check("rst_ringing", ringing, 1'b0);
    check("rst_snoozing", snoozing, 1'b0);
    check("rst_buzzer", buzzer, 1'b0);
    rst_n = 1'b1;
    run(3);

    // Full ring with equality held: exactly RING_CYC cycles, no re-fire
    cnt_ring = 0;
    set_cur(8'd7, 8'd30, 8'd0);
    run(45);
    check_int("ring_len", cnt_ring, RING_CYC);
    set_cur(8'd7, 8'd30, 8'd1);
    run(2);

    // Snooze then automatic re-ring
    set_cur(8'd7, 8'd30, 8'd0); run(1);
    set_cur(8'd7, 8'd30, 8'd1); run(5);
    cnt_ring = 0; cnt_snz = 0;
    snooze_key = 1'b0; run(3);
    snooze_key = 1'b1; run(700);
    check_int("snooze_len", cnt_snz, SNZ_CYC);
    check_int("rering_len", cnt_ring, RING_CYC + 1);

    // Stop and snooze on the same cycle: stop wins
    set_cur(8'd7, 8'd30, 8'd0); run(1);
    set_cur(8'd7, 8'd30, 8'd1); run(4);
    cnt_snz = 0;
    stop_key = 1'b0; snooze_key = 1'b0; run(2);
    stop_key = 1'b1; snooze_key = 1'b1; run(10);
    check_int("both_keys_snz", cnt_snz, 0);
    check("both_keys_idle", ringing, 1'b0);

    // Equality held 20 cycles, stop at cycle 5, then a new equality window fires
    cnt_ring = 0;
    set_cur(8'd7, 8'd30, 8'd0); run(5);
    stop_key = 1'b0; run(1);
    stop_key = 1'b1; run(14);
    check_int("stop_ring_len", cnt_ring, 6);
    set_cur(8'd7, 8'd30, 8'd1); run(1);
    set_cur(8'd7, 8'd30, 8'd0); run(1);
    check("refire", ringing, 1'b1);
    stop_key = 1'b0; run(1);
    stop_key = 1'b1; run(2);

    // Setting mode or disabled alarm at the match edge
    set_cur(8'd7, 8'd30, 8'd1); run(1);
    state_mode = 4'd3; set_cur(8'd7, 8'd30, 8'd0); run(3);
    check("mode3_noring", ringing, 1'b0);
    state_mode = 4'd0; run(2);
    set_cur(8'd7, 8'd30, 8'd1); alarm_en = 1'b0; run(1);
    set_cur(8'd7, 8'd30, 8'd0); run(2);
    check("en0_noring", ringing, 1'b0);
    alarm_en = 1'b1; run(2);

    // Dropping enable during snooze
    set_cur(8'd7, 8'd30, 8'd1); run(1);
    set_cur(8'd7, 8'd30, 8'd0); run(1);
    snooze_key = 1'b0; run(2);
    snooze_key = 1'b1; run(5);
    check("in_snooze", snoozing, 1'b1);
    alarm_en = 1'b0; run(1);
    check("en_drop_idle", snoozing, 1'b0);
    alarm_en = 1'b1;

    // Asynchronous reset mid-ring, equality still present after release
    set_cur(8'd7, 8'd30, 8'd1); run(1);
    set_cur(8'd7, 8'd30, 8'd0); run(1);
    found = 0;
    for (int i = 0; i < 25 && !found; i++) begin
      step();
      if (m_buz) found = 1;
    end
    check("buzzer_seen", found, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_ringing", ringing, 1'b0);
    check("rst_mid_buzzer", buzzer, 1'b0);
    check("rst_mid_snoozing", snoozing, 1'b0);
    model_reset();
    @(posedge clk_50M); #1;
    rst_n = 1'b1;
    run(10);
    check("post_rst_idle", ringing, 1'b0);

    // Random phase
    set_cur(8'd7, 8'd30, 8'd1);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4)      set_cur(8'd7, 8'd30, 8'd0);
      else if (r < 8) set_cur(8'd7, 8'd30, 8'($urandom_range(1, 59)));
      stop_key   = ($urandom_range(0, 149) != 0);
      snooze_key = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 399) == 0) alarm_en = ~alarm_en;
      state_mode = ($urandom_range(0, 19) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
